// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding and default field widths.
package pipe_pkg;

  localparam int unsigned WB_CTRL_W = 4;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  // MEM/WB payload: DM read data, ALU result, rd index and pc+4.
  localparam int unsigned MEM_WB_DATA_W = 3 * XLEN + REG_IDX_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StOne   = ST_ONE,
    StTwo   = ST_TWO
  } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline beat: control + data register with load enable and a control-only clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = WB_CTRL_W,
  parameter int unsigned DATA_W = MEM_WB_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Clearing touches only ctrl so a killed entry reads as a NOP while data stays put.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load_i) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end else if (clr_ctrl_i) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, optional skid entry and flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = WB_CTRL_W,
  parameter int unsigned DATA_W = MEM_WB_DATA_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  stage_state_e state_d, state_q;

  logic              in_ready;
  logic              accept;
  logic              out_valid;
  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic [CTRL_W-1:0] main_ctrl_in, main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data_in, main_data, skid_data;

  assign out_valid = (state_q != StEmpty);

  // With SKID the ready depends on state only, so out_ready_i never reaches in_ready_o.
  always_comb begin
    in_ready = 1'b0;
    if (!rst_i) begin
      if (SKID) begin
        in_ready = (state_q != StTwo);
      end else begin
        in_ready = !out_valid || out_ready_i;
      end
    end
  end

  assign accept = in_valid_i && in_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (accept) begin
            if (out_ready_i) begin
              main_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = StTwo;
            end
          end else if (out_ready_i) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_ready_i) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;
  assign main_data_in = main_from_skid ? skid_data : in_data_i;

  pipe_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (main_load),
    .clr_ctrl_i (flush_i),
    .ctrl_i     (main_ctrl_in),
    .data_i     (main_data_in),
    .ctrl_o     (main_ctrl),
    .data_o     (main_data)
  );

  pipe_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (skid_load),
    .clr_ctrl_i (flush_i),
    .ctrl_i     (in_ctrl_i),
    .data_i     (in_data_i),
    .ctrl_o     (skid_ctrl),
    .data_o     (skid_data)
  );

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign out_ctrl_o  = out_valid ? main_ctrl : '0;
  assign out_data_o  = main_data;
  assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: instance 0 uses the skid buffer, instance 1 does not.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 101;
  localparam int unsigned EW = CW + DW;

  logic clk;
  logic rst;
  logic [1:0] flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl [2];
  logic [CW-1:0] out_ctrl [2];
  logic [DW-1:0] in_data [2];
  logic [DW-1:0] out_data [2];
  logic [1:0] occ [2];

  // Directed expectations for the currently visible state, written by stimulus only.
  logic [1:0] ex_occ [2];
  logic       ex_rdy [2];
  logic       ex_vld [2];

  logic [EW-1:0] sbq [2][$];
  logic [EW-1:0] held [2];
  logic [EW-1:0] exp_beat;
  bit   stall [2];
  int   n_chk;
  int   n_err;
  int   probe_cnt;
  int   probe_seen;
  bit   done;
  event probe_ev;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush[0]),
    .in_valid_i  (in_valid[0]),
    .in_ready_o  (in_ready[0]),
    .in_ctrl_i   (in_ctrl[0]),
    .in_data_i   (in_data[0]),
    .out_valid_o (out_valid[0]),
    .out_ready_i (out_ready[0]),
    .out_ctrl_o  (out_ctrl[0]),
    .out_data_o  (out_data[0]),
    .occupancy_o (occ[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut_single (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush[1]),
    .in_valid_i  (in_valid[1]),
    .in_ready_o  (in_ready[1]),
    .in_ctrl_i   (in_ctrl[1]),
    .in_data_i   (in_data[1]),
    .out_valid_o (out_valid[1]),
    .out_ready_i (out_ready[1]),
    .out_ctrl_o  (out_ctrl[1]),
    .out_data_o  (out_data[1]),
    .occupancy_o (occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [127:0] got,
                     input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, idx, got, want);
    end
  endtask

  task automatic drive(input int i, input bit v, input logic [3:0] c, input logic [15:0] d,
                       input bit ordy, input bit fl);
    in_valid[i]  = v;
    in_ctrl[i]   = c;
    in_data[i]   = DW'(d);
    out_ready[i] = ordy;
    flush[i]     = fl;
  endtask

  task automatic expect_st(input int i, input logic [1:0] o, input logic r, input logic v);
    ex_occ[i] = o;
    ex_rdy[i] = r;
    ex_vld[i] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: directed state checks plus scoreboard pop on every output transfer.
  always begin
    @(negedge clk or probe_ev);
    if (probe_cnt != probe_seen) begin
      probe_seen = probe_cnt;
      for (int i = 0; i < 2; i++) begin
        chk("async_out_valid", i, 128'(out_valid[i]), 128'(0));
        chk("async_occupancy", i, 128'(occ[i]), 128'(0));
        chk("async_in_ready", i, 128'(in_ready[i]), 128'(0));
        chk("async_out_ctrl", i, 128'(out_ctrl[i]), 128'(0));
        chk("async_out_data", i, 128'(out_data[i]), 128'(0));
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("occupancy", i, 128'(occ[i]), 128'(ex_occ[i]));
        chk("in_ready", i, 128'(in_ready[i]), 128'(ex_rdy[i]));
        chk("out_valid", i, 128'(out_valid[i]), 128'(ex_vld[i]));
        if (!out_valid[i]) chk("bubble_ctrl", i, 128'(out_ctrl[i]), 128'(0));
        if (rst) begin
          sbq[i].delete();
          stall[i] = 1'b0;
        end else begin
          if (stall[i] && out_valid[i]) begin
            chk("stall_stable", i, 128'({out_ctrl[i], out_data[i]}), 128'(held[i]));
          end
          stall[i] = out_valid[i] && !out_ready[i];
          held[i]  = {out_ctrl[i], out_data[i]};
          if (out_valid[i] && out_ready[i]) begin
            if (sbq[i].size() == 0) begin
              chk("unexpected_out", i, 128'({out_ctrl[i], out_data[i]}), 128'(0) - 128'(1));
            end else begin
              exp_beat = sbq[i].pop_front();
              chk("out_beat", i, 128'({out_ctrl[i], out_data[i]}), 128'(exp_beat));
            end
          end
          if (flush[i]) begin
            sbq[i].delete();
          end else if (in_valid[i] && in_ready[i]) begin
            sbq[i].push_back({in_ctrl[i], in_data[i]});
          end
        end
      end
      if (done) begin
        for (int i = 0; i < 2; i++) chk("drained", i, 128'(sbq[i].size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    probe_cnt = 0;
    probe_seen = 0;
    done = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
      expect_st(i, 2'd0, 1'b0, 1'b0);
      stall[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_st(0, 2'd0, 1'b1, 1'b0);
    expect_st(1, 2'd0, 1'b1, 1'b0);
    tick();

    // Streaming through the skid instance
    drive(0, 1'b1, 4'hA, 16'h1, 1'b1, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    drive(0, 1'b1, 4'hA, 16'h2, 1'b1, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b1, 4'hA, 16'h3, 1'b1, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    expect_st(0, 2'd0, 1'b1, 1'b0); tick();

    // Backpressure fills the skid entry, then drains in order
    drive(0, 1'b1, 4'h6, 16'h5, 1'b0, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    drive(0, 1'b1, 4'h6, 16'h6, 1'b0, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0); expect_st(0, 2'd2, 1'b0, 1'b1); tick();
    expect_st(0, 2'd2, 1'b0, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0); expect_st(0, 2'd2, 1'b0, 1'b1); tick();
    expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    expect_st(0, 2'd0, 1'b1, 1'b0); tick();

    // Flush with two held entries and a valid input beat
    drive(0, 1'b1, 4'h9, 16'h7, 1'b0, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    drive(0, 1'b1, 4'h9, 16'h8, 1'b0, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b1, 4'h9, 16'h9, 1'b0, 1'b1); expect_st(0, 2'd2, 1'b0, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();

    // Flush while draining: held beat still goes out, accepted input is killed
    drive(0, 1'b1, 4'hC, 16'hA, 1'b1, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    drive(0, 1'b1, 4'hC, 16'hB, 1'b1, 1'b1); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();

    // Single-entry instance: combinational ready, replace on simultaneous drain
    drive(1, 1'b1, 4'h3, 16'h21, 1'b0, 1'b0); expect_st(1, 2'd0, 1'b1, 1'b0); tick();
    drive(1, 1'b1, 4'h3, 16'h22, 1'b0, 1'b0); expect_st(1, 2'd1, 1'b0, 1'b1); tick();
    drive(1, 1'b1, 4'h3, 16'h22, 1'b1, 1'b0); expect_st(1, 2'd1, 1'b1, 1'b1); tick();
    drive(1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0); expect_st(1, 2'd1, 1'b0, 1'b1); tick();
    drive(1, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0); expect_st(1, 2'd1, 1'b1, 1'b1); tick();
    expect_st(1, 2'd0, 1'b1, 1'b0); tick();

    // Asynchronous reset between edges with two beats held
    drive(0, 1'b1, 4'h5, 16'h11, 1'b0, 1'b0); expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    drive(0, 1'b1, 4'h5, 16'h12, 1'b0, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0); expect_st(0, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    expect_st(0, 2'd0, 1'b0, 1'b0);
    expect_st(1, 2'd0, 1'b0, 1'b0);
    #1;
    probe_cnt++;
    -> probe_ev;
    tick();
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 4'h5, 16'h3C, 1'b1, 1'b0);
    expect_st(0, 2'd0, 1'b1, 1'b0);
    expect_st(1, 2'd0, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0); expect_st(0, 2'd1, 1'b1, 1'b1); tick();
    expect_st(0, 2'd0, 1'b1, 1'b0); tick();
    done = 1'b1;
    repeat (3) tick();
  end

endmodule
